mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 18 +
 rtl/arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, response-state encoding and grant-vector bit positions for the
// instruction/data memory arbiter.
package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Bit positions inside the one-hot grant vector produced by arb_pick.
  localparam int GNT_F = 0;
  localparam int GNT_D = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker: data normally wins a collision, but yields to
// fetch when the previous grant already went to data.
module arb_pick
  import mem_pkg::*;
(
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       last_grant_data,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (data_req && (!fetch_req || !last_grant_data)) begin
      grant[GNT_D] = 1'b1;
    end else if (fetch_req) begin
      grant[GNT_F] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a
// load/store port, returning read data one cycle after the grant.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output resp_state_e       state_dbg
);

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; req may drop afterwards. A read answers with exactly one valid
  // cycle on its own port in the following cycle; stores never answer.

  logic [1:0]        pick;
  logic              last_grant_data_q;
  logic              any_gnt;
  logic              read_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W-1:0] addr_q;

  logic              st_valid_q;
  logic [ADDR_W-1:0] st_addr_q;
  logic [DATA_W-1:0] st_data_q;
  logic              fwd_hit;
  logic              fwd_pend_q;
  logic [DATA_W-1:0] fwd_data_q;

  resp_state_e       state_q;
  resp_state_e       state_d;
  logic [DATA_W-1:0] resp_word;
  logic [DATA_W-1:0] fetch_hold_q;
  logic [DATA_W-1:0] data_hold_q;

  arb_pick u_arb_pick (
    .fetch_req       (fetch_req),
    .data_req        (data_req),
    .last_grant_data (last_grant_data_q),
    .grant           (pick)
  );

  // Reset masks the grants so nothing reaches the memory while it is preloaded.
  assign fetch_gnt = pick[GNT_F] & ~reset;
  assign data_gnt  = pick[GNT_D] & ~reset;
  assign any_gnt   = fetch_gnt | data_gnt;
  assign read_gnt  = fetch_gnt | (data_gnt & ~data_we);
  assign gnt_addr  = data_gnt ? data_addr : fetch_addr;

  assign mem_addr  = reset ? '0 : (any_gnt ? gnt_addr : addr_q);
  assign mem_wdata = data_wdata;
  assign mem_write = data_gnt & data_we;

  // A read granted right after a store to the same word returns the store data.
  assign fwd_hit = read_gnt & st_valid_q & (gnt_addr == st_addr_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q            <= '0;
      last_grant_data_q <= 1'b0;
      st_valid_q        <= 1'b0;
      st_addr_q         <= '0;
      st_data_q         <= '0;
      fwd_pend_q        <= 1'b0;
      fwd_data_q        <= '0;
    end else begin
      if (any_gnt) begin
        addr_q            <= gnt_addr;
        last_grant_data_q <= data_gnt;
      end
      st_valid_q <= mem_write;
      if (mem_write) begin
        st_addr_q <= data_addr;
        st_data_q <= data_wdata;
      end
      fwd_pend_q <= fwd_hit;
      fwd_data_q <= st_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (fetch_gnt) begin
      state_d = RESP_F;
    end else if (data_gnt && !data_we) begin
      state_d = RESP_D;
    end
  end

  assign state_dbg   = state_q;
  assign resp_word   = fwd_pend_q ? fwd_data_q : mem_rdata;
  assign fetch_valid = (state_q == RESP_F) & ~reset;
  assign data_valid  = (state_q == RESP_D) & ~reset;

  // Read data is live during the valid cycle and held in a register afterwards.
  assign fetch_data = reset ? '0 : (fetch_valid ? resp_word : fetch_hold_q);
  assign data_rdata = reset ? '0 : (data_valid ? resp_word : data_hold_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      if (fetch_valid) fetch_hold_q <= resp_word;
      if (data_valid)  data_hold_q  <= resp_word;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, alternation, forwarding,
// reset during a pending load and back-to-back stores.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_gnt;
  logic        data_valid;
  logic [15:0] data_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;
  resp_state_e state_dbg;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_valid  (data_valid),
    .data_rdata  (data_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .state_dbg   (state_dbg)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change 1 time unit after the rising edge and outputs
  // are sampled 3 units after it, well away from either clock edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
  endtask

  task automatic reset_dut();
    cyc();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    fetch_req = 1'b1; fetch_addr = 16'h0033;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0044; data_wdata = 16'h5a5a;
    mem_rdata = 16'hffff;
    cyc();
    #2;
    checks++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL rst_fetch_gnt got=%0h exp=0", fetch_gnt); end
    checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL rst_data_gnt got=%0h exp=0", data_gnt); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%0h exp=0", mem_write); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (fetch_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL rst_valids got=%0b%0b exp=00", fetch_valid, data_valid); end
    checks++; if (fetch_data !== 16'h0000) begin errors++; $display("FAIL rst_fetch_data got=%0h exp=0", fetch_data); end
    checks++; if (data_rdata !== 16'h0000) begin errors++; $display("FAIL rst_data_rdata got=%0h exp=0", data_rdata); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, IDLE); end
    cyc();
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_fetch_basic();
    reset_dut();
    cyc();
    fetch_req = 1'b1; fetch_addr = 16'h0000;
    #2;
    checks++; if (fetch_gnt !== 1'b1 || data_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got=%0b%0b exp=10", fetch_gnt, data_gnt); end
    checks++; if (mem_addr !== 16'h0000 || mem_write !== 1'b0) begin errors++; $display("FAIL fetch_mem got=%0h/%0b exp=0/0", mem_addr, mem_write); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid got=%0b exp=0", fetch_valid); end
    cyc();
    fetch_req = 1'b0; mem_rdata = 16'h0008;
    #2;
    checks++; if (fetch_valid !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid got=%0b%0b exp=10", fetch_valid, data_valid); end
    checks++; if (fetch_data !== 16'h0008) begin errors++; $display("FAIL fetch_data got=%0h exp=8", fetch_data); end
    cyc();
    mem_rdata = 16'hffff;
    #2;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_one_pulse got=%0b exp=0", fetch_valid); end
    checks++; if (fetch_data !== 16'h0008) begin errors++; $display("FAIL fetch_hold got=%0h exp=8", fetch_data); end
  endtask

  task automatic test_alternation();
    logic        exp_f[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_addr[4] = '{16'h0200, 16'h0101, 16'h0202, 16'h0103};
    logic [15:0] rd;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      cyc();
      fetch_req = (i < 4); fetch_addr = 16'h0100 + 16'(i);
      data_req  = (i < 4); data_we = 1'b0; data_addr = 16'h0200 + 16'(i);
      mem_rdata = 16'ha000 + 16'(i);
      #2;
      if (i < 4) begin
        checks++; if (fetch_gnt !== exp_f[i] || data_gnt !== !exp_f[i]) begin errors++; $display("FAIL alt_gnt[%0d] got=%0b%0b exp=%0b%0b", i, fetch_gnt, data_gnt, exp_f[i], !exp_f[i]); end
        checks++; if (mem_addr !== exp_addr[i]) begin errors++; $display("FAIL alt_addr[%0d] got=%0h exp=%0h", i, mem_addr, exp_addr[i]); end
      end
      if (i > 0) begin
        checks++; if (fetch_valid !== exp_f[i-1] || data_valid !== !exp_f[i-1]) begin errors++; $display("FAIL alt_valid[%0d] got=%0b%0b exp=%0b%0b", i, fetch_valid, data_valid, exp_f[i-1], !exp_f[i-1]); end
        rd = exp_f[i-1] ? fetch_data : data_rdata;
        checks++; if (rd !== 16'ha000 + 16'(i)) begin errors++; $display("FAIL alt_data[%0d] got=%0h exp=%0h", i, rd, 16'ha000 + 16'(i)); end
      end
    end
    cyc();
    idle_inputs();
    #2;
    checks++; if (fetch_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL alt_tail_valid got=%0b%0b exp=00", fetch_valid, data_valid); end
    checks++; if (mem_addr !== 16'h0103) begin errors++; $display("FAIL alt_addr_hold got=%0h exp=103", mem_addr); end
    checks++; if (data_rdata !== 16'ha003 || fetch_data !== 16'ha004) begin errors++; $display("FAIL alt_hold got=%0h/%0h exp=a003/a004", data_rdata, fetch_data); end
  endtask

  task automatic test_forward();
    reset_dut();
    cyc();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0005; data_wdata = 16'h1234;
    #2;
    checks++; if (data_gnt !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL fwd_store got=%0b/%0b exp=1/1", data_gnt, mem_write); end
    checks++; if (mem_addr !== 16'h0005 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL fwd_store_bus got=%0h/%0h exp=5/1234", mem_addr, mem_wdata); end
    cyc();
    data_we = 1'b0; data_wdata = 16'h0000; mem_rdata = 16'hdead;
    #2;
    checks++; if (data_gnt !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL fwd_load got=%0b/%0b exp=1/0", data_gnt, mem_write); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL fwd_store_valid got=%0b exp=0", data_valid); end
    cyc();
    data_req = 1'b0; mem_rdata = 16'hbeef;
    #2;
    checks++; if (data_valid !== 1'b1 || data_rdata !== 16'h1234) begin errors++; $display("FAIL fwd_data got=%0b/%0h exp=1/1234", data_valid, data_rdata); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL fwd_write_tail got=%0b exp=0", mem_write); end
  endtask

  task automatic test_no_forward();
    cyc();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0005; data_wdata = 16'h5555;
    cyc();
    data_we = 1'b0; data_addr = 16'h0006; mem_rdata = 16'h1111;
    #2;
    checks++; if (mem_addr !== 16'h0006 || data_gnt !== 1'b1) begin errors++; $display("FAIL nofwd_load got=%0h/%0b exp=6/1", mem_addr, data_gnt); end
    cyc();
    data_req = 1'b0; mem_rdata = 16'h6666;
    #2;
    checks++; if (data_valid !== 1'b1 || data_rdata !== 16'h6666) begin errors++; $display("FAIL nofwd_data got=%0b/%0h exp=1/6666", data_valid, data_rdata); end
  endtask

  task automatic test_reset_mid();
    cyc();
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0007;
    #2;
    checks++; if (data_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got=%0b exp=1", data_gnt); end
    cyc();
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0009; mem_rdata = 16'h7777;
    #2;
    checks++; if (data_valid !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b%0b exp=00", fetch_valid, data_valid); end
    checks++; if (data_gnt !== 1'b0 || fetch_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gnt_off got=%0b%0b exp=00", fetch_gnt, data_gnt); end
    checks++; if (mem_write !== 1'b0 || mem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_mem got=%0b/%0h exp=0/0", mem_write, mem_addr); end
    checks++; if (data_rdata !== 16'h0000 || fetch_data !== 16'h0000) begin errors++; $display("FAIL rmid_data got=%0h/%0h exp=0/0", data_rdata, fetch_data); end
    cyc();
    #2;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rmid_state got=%0d exp=%0d", state_dbg, IDLE); end
    cyc();
    reset = 1'b0;
    idle_inputs();
    mem_rdata = 16'h7777;
    #2;
    checks++; if (data_valid !== 1'b0 || data_rdata !== 16'h0000) begin errors++; $display("FAIL rmid_dropped got=%0b/%0h exp=0/0", data_valid, data_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wd[3] = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_req = 1'b1; data_we = 1'b1; data_addr = 16'h000a + 16'(i); data_wdata = wd[i];
      #2;
      checks++; if (data_gnt !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL b2b_store[%0d] got=%0b/%0b exp=1/1", i, data_gnt, mem_write); end
      checks++; if (data_valid !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d] got=%0b%0b exp=00", i, fetch_valid, data_valid); end
    end
    cyc();
    fetch_req = 1'b1; fetch_addr = 16'h000c;
    data_we = 1'b0; data_addr = 16'h0040; data_wdata = 16'h0000;
    #2;
    checks++; if (fetch_gnt !== 1'b1 || data_gnt !== 1'b0) begin errors++; $display("FAIL b2b_alt got=%0b%0b exp=10", fetch_gnt, data_gnt); end
    checks++; if (data_valid !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL b2b_after got=%0b/%0b exp=0/0", data_valid, mem_write); end
    cyc();
    idle_inputs();
    mem_rdata = 16'h0bad;
    #2;
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== 16'h3333) begin errors++; $display("FAIL b2b_fetch_fwd got=%0b/%0h exp=1/3333", fetch_valid, fetch_data); end
    checks++; if (mem_addr !== 16'h000c || mem_write !== 1'b0) begin errors++; $display("FAIL b2b_hold got=%0h/%0b exp=c/0", mem_addr, mem_write); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_basic();
    test_alternation();
    test_forward();
    test_no_forward();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
